// File: rtl/countdown_timer_core.sv
// Countdown timer counting core: set hh:mm:ss in IDLE, count down in
// centiseconds while running, then flag expiry and blink the display.
// Time fields use the stopwatch widths so the FND controller can show them.
`timescale 1ns/1ps
module countdown_timer_core #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 100,
  parameter int BLINK_TICKS = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run,
  input  logic       i_clr,
  input  logic       i_hour_up,
  input  logic       i_min_up,
  input  logic       i_sec_up,
  output logic [6:0] msec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       running,
  output logic       expired,
  output logic       blink
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int BW  = $clog2(BLINK_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        r_state, w_state;
  logic [6:0]    r_msec, w_msec;
  logic [5:0]    r_sec, w_sec, r_min, w_min;
  logic [4:0]    r_hour, w_hour;
  logic [5:0]    r_p_sec, w_p_sec, r_p_min, w_p_min;
  logic [4:0]    r_p_hour, w_p_hour;
  logic [PW-1:0] r_presc, w_presc;
  logic [BW-1:0] r_bcnt, w_bcnt;
  logic          r_blink, w_blink;

  logic          w_tick, w_nonzero, w_last;
  logic          w_borrow_s, w_borrow_m, w_borrow_h;
  logic [6:0]    w_dec_msec;
  logic [5:0]    w_dec_sec, w_dec_min;
  logic [4:0]    w_dec_hour;

  assign w_tick    = (r_presc == PW'(DIV - 1));
  assign w_nonzero = |{r_hour, r_min, r_sec, r_msec};
  assign w_last    = (r_hour == 5'd0) && (r_min == 6'd0) && (r_sec == 6'd0) && (r_msec == 7'd1);

  // One-centisecond decrement with a borrow rippling msec -> sec -> min -> hour
  always_comb begin
    w_borrow_s = (r_msec == 7'd0);
    w_dec_msec = w_borrow_s ? 7'd99 : r_msec - 7'd1;
    w_borrow_m = w_borrow_s && (r_sec == 6'd0);
    w_dec_sec  = w_borrow_s ? ((r_sec == 6'd0) ? 6'd59 : r_sec - 6'd1) : r_sec;
    w_borrow_h = w_borrow_m && (r_min == 6'd0);
    w_dec_min  = w_borrow_m ? ((r_min == 6'd0) ? 6'd59 : r_min - 6'd1) : r_min;
    w_dec_hour = (w_borrow_h && (r_hour != 5'd0)) ? r_hour - 5'd1 : r_hour;
  end

  // Next-state and next-datapath decode; clear overrides every state
  always_comb begin
    w_state  = r_state;
    w_msec   = r_msec;
    w_sec    = r_sec;
    w_min    = r_min;
    w_hour   = r_hour;
    w_p_sec  = r_p_sec;
    w_p_min  = r_p_min;
    w_p_hour = r_p_hour;
    w_presc  = r_presc;
    w_bcnt   = r_bcnt;
    w_blink  = r_blink;
    if (i_clr) begin
      w_state  = S_IDLE;
      w_msec   = 7'd0;
      w_sec    = 6'd0;
      w_min    = 6'd0;
      w_hour   = 5'd0;
      w_p_sec  = 6'd0;
      w_p_min  = 6'd0;
      w_p_hour = 5'd0;
      w_presc  = '0;
      w_bcnt   = '0;
      w_blink  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_presc = '0;
          w_msec  = 7'd0;
          if (i_run) begin
            if (w_nonzero) begin
              w_state  = S_RUN;
              w_p_sec  = r_sec;
              w_p_min  = r_min;
              w_p_hour = r_hour;
            end
          end else begin
            if (i_hour_up) w_hour = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
            if (i_min_up)  w_min  = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
            if (i_sec_up)  w_sec  = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
          end
        end
        S_RUN: begin
          if (i_run) begin
            w_state = S_PAUSE;
            w_presc = '0;
          end else if (w_tick) begin
            w_presc = '0;
            w_msec  = w_dec_msec;
            w_sec   = w_dec_sec;
            w_min   = w_dec_min;
            w_hour  = w_dec_hour;
            if (w_last) begin
              w_state = S_DONE;
              w_bcnt  = '0;
              w_blink = 1'b1;
            end
          end else begin
            w_presc = r_presc + PW'(1);
          end
        end
        S_PAUSE: begin
          if (i_run) begin
            w_state = S_RUN;
            w_presc = '0;
          end
        end
        default: begin
          w_presc = w_tick ? '0 : r_presc + PW'(1);
          if (i_run) begin
            w_state = S_IDLE;
            w_msec  = 7'd0;
            w_sec   = r_p_sec;
            w_min   = r_p_min;
            w_hour  = r_p_hour;
            w_presc = '0;
            w_bcnt  = '0;
            w_blink = 1'b1;
          end else if (w_tick) begin
            if (r_bcnt == BW'(BLINK_TICKS - 1)) begin
              w_bcnt  = '0;
              w_blink = ~r_blink;
            end else begin
              w_bcnt = r_bcnt + BW'(1);
            end
          end
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_msec   <= 7'd0;
      r_sec    <= 6'd0;
      r_min    <= 6'd0;
      r_hour   <= 5'd0;
      r_p_sec  <= 6'd0;
      r_p_min  <= 6'd0;
      r_p_hour <= 5'd0;
      r_presc  <= '0;
      r_bcnt   <= '0;
      r_blink  <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_msec   <= w_msec;
      r_sec    <= w_sec;
      r_min    <= w_min;
      r_hour   <= w_hour;
      r_p_sec  <= w_p_sec;
      r_p_min  <= w_p_min;
      r_p_hour <= w_p_hour;
      r_presc  <= w_presc;
      r_bcnt   <= w_bcnt;
      r_blink  <= w_blink;
    end
  end

  assign msec    = r_msec;
  assign sec     = r_sec;
  assign min     = r_min;
  assign hour    = r_hour;
  assign running = (r_state == S_RUN);
  assign expired = (r_state == S_DONE);
  assign blink   = r_blink;

endmodule
